mips_cpu_bus: RTL and testbench

- Multicycle, non-pipelined MIPS-I subset CPU with a single Avalon-style memory-mapped bus for both instruction fetch and data access.
- Starts at reset vector 0xBFC00000.
- Runs until a jump leaves the PC at 0x00000000, then halts and drops active.
- Exposes $2 (v0) for checking by top-level system benches.

---
 rtl/mips_pkg.sv | 53 +++++
 rtl/mips_regfile.sv | 44 ++++
 rtl/mips_cpu_bus.sv | 266 ++++++++++++++++++++++++++
 tb/tb_mips_cpu_bus.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the mips_cpu_bus multicycle MIPS-I subset core:
// opcode/funct encodings, the control state type and small decode helpers.
package mips_pkg;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 general-purpose register file: two asynchronous read ports, one
// synchronous write port, $0 hardwired to zero and a dedicated $2 tap.
module mips_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  raddr_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_a,
    output logic [31:0] rdata_b,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    output logic [31:0] v0
);

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    // Next register contents; $0 is never written so it stays at its reset value of zero
    always_comb begin
        regs_d = regs_q;
        if (we && (waddr != 5'd0)) begin
            regs_d[waddr] = wdata;
        end else begin
            regs_d[5'd0] = 32'd0;
        end
    end

    // Register storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata_a = regs_q[raddr_a];
    assign rdata_b = regs_q[raddr_b];
    assign v0      = regs_q[2];

endmodule

// File: rtl/mips_cpu_bus.sv
// Multicycle, non-pipelined MIPS-I subset CPU sharing one Avalon-MM bus for
// instruction fetch and data access. Halts when the PC to fetch becomes 0.
module mips_cpu_bus
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        active,
    output logic [31:0] register_v0,
    output logic [31:0] address,
    output logic        write,
    output logic        read,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, instr_q, instr_d, target_q, target_d;
    logic        pending_q, pending_d, ld_wait_q, ld_wait_d;
    logic        active_q, active_d, read_q, read_d, write_q, write_d;
    logic [31:0] address_q, address_d, writedata_q, writedata_d;
    logic [3:0]  byteenable_q, byteenable_d;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] imm_s, imm_z, rs_val, rt_val, ea, seq_pc, pc_plus4, pc_plus8;
    logic [31:0] alu_res, br_tgt, fetch_pc, rf_wdata;
    logic [4:0]  alu_dst, rf_waddr;
    logic        alu_we, br_taken, rf_we, is_mem, go_fetch;

    assign opcode   = instr_q[31:26];
    assign rs       = instr_q[25:21];
    assign rt       = instr_q[20:16];
    assign rd       = instr_q[15:11];
    assign shamt    = instr_q[10:6];
    assign funct    = instr_q[5:0];
    assign imm_s    = sext16(instr_q[15:0]);
    assign imm_z    = {16'd0, instr_q[15:0]};
    assign ea       = rs_val + imm_s;
    assign pc_plus4 = pc_q + 32'd4;
    assign pc_plus8 = pc_q + 32'd8;
    assign is_mem   = (opcode == OP_LW) || (opcode == OP_SW);
    // A pending taken branch/jump redirects the PC after its delay slot
    assign seq_pc   = pending_q ? target_q : pc_plus4;

    mips_regfile u_regfile (
        .clk     (clk),
        .rst     (reset),
        .raddr_a (rs),
        .raddr_b (rt),
        .rdata_a (rs_val),
        .rdata_b (rt_val),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .v0      (register_v0)
    );

    // Execute-stage datapath: ALU result, destination and branch decision
    always_comb begin
        alu_res  = 32'd0;
        alu_we   = 1'b0;
        alu_dst  = rt;
        br_taken = 1'b0;
        br_tgt   = pc_plus4 + (imm_s << 2);
        case (opcode)
            OP_SPECIAL: begin
                alu_dst = rd;
                alu_we  = 1'b1;
                case (funct)
                    FN_SLL:  alu_res = rt_val << shamt;
                    FN_SRL:  alu_res = rt_val >> shamt;
                    FN_SRA:  alu_res = $signed(rt_val) >>> shamt;
                    FN_SLLV: alu_res = rt_val << rs_val[4:0];
                    FN_SRLV: alu_res = rt_val >> rs_val[4:0];
                    FN_SRAV: alu_res = $signed(rt_val) >>> rs_val[4:0];
                    FN_JR: begin
                        alu_we   = 1'b0;
                        br_taken = 1'b1;
                        br_tgt   = rs_val;
                    end
                    FN_JALR: begin
                        alu_res  = pc_plus8;
                        br_taken = 1'b1;
                        br_tgt   = rs_val;
                    end
                    FN_ADDU: alu_res = rs_val + rt_val;
                    FN_SUBU: alu_res = rs_val - rt_val;
                    FN_AND:  alu_res = rs_val & rt_val;
                    FN_OR:   alu_res = rs_val | rt_val;
                    FN_XOR:  alu_res = rs_val ^ rt_val;
                    FN_NOR:  alu_res = ~(rs_val | rt_val);
                    FN_SLT:  alu_res = {31'd0, $signed(rs_val) < $signed(rt_val)};
                    FN_SLTU: alu_res = {31'd0, rs_val < rt_val};
                    default: alu_we = 1'b0;
                endcase
            end
            OP_J: begin
                br_taken = 1'b1;
                br_tgt   = {pc_plus4[31:28], instr_q[25:0], 2'b00};
            end
            OP_JAL: begin
                br_taken = 1'b1;
                br_tgt   = {pc_plus4[31:28], instr_q[25:0], 2'b00};
                alu_we   = 1'b1;
                alu_dst  = 5'd31;
                alu_res  = pc_plus8;
            end
            OP_BEQ:   br_taken = (rs_val == rt_val);
            OP_BNE:   br_taken = (rs_val != rt_val);
            OP_BLEZ:  br_taken = rs_val[31] || (rs_val == 32'd0);
            OP_BGTZ:  br_taken = !rs_val[31] && (rs_val != 32'd0);
            OP_ADDIU: begin alu_we = 1'b1; alu_res = rs_val + imm_s; end
            OP_SLTI:  begin alu_we = 1'b1; alu_res = {31'd0, $signed(rs_val) < $signed(imm_s)}; end
            OP_SLTIU: begin alu_we = 1'b1; alu_res = {31'd0, rs_val < imm_s}; end
            OP_ANDI:  begin alu_we = 1'b1; alu_res = rs_val & imm_z; end
            OP_ORI:   begin alu_we = 1'b1; alu_res = rs_val | imm_z; end
            OP_XORI:  begin alu_we = 1'b1; alu_res = rs_val ^ imm_z; end
            OP_LUI:   begin alu_we = 1'b1; alu_res = {instr_q[15:0], 16'd0}; end
            default:  alu_we = 1'b0;
        endcase
    end

    // Control FSM next-state and registered bus outputs; defaults hold everything during a stall
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        target_d     = target_q;
        pending_d    = pending_q;
        ld_wait_d    = ld_wait_q;
        active_d     = active_q;
        read_d       = read_q;
        write_d      = write_q;
        address_d    = address_q;
        writedata_d  = writedata_q;
        byteenable_d = byteenable_q;
        rf_we        = 1'b0;
        rf_waddr     = alu_dst;
        rf_wdata     = alu_res;
        go_fetch     = 1'b0;
        fetch_pc     = pc_q;
        case (state_q)
            ST_FETCH: begin
                if (!read_q) begin
                    read_d       = 1'b1;
                    address_d    = pc_q;
                    byteenable_d = 4'b1111;
                end else if (!waitrequest) begin
                    read_d  = 1'b0;
                    state_d = ST_DECODE;
                end else begin
                    read_d = 1'b1;
                end
            end
            ST_DECODE: begin
                instr_d = readdata;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                pc_d      = seq_pc;
                pending_d = br_taken;
                target_d  = br_tgt;
                if (is_mem) begin
                    state_d      = ST_MEM;
                    address_d    = {ea[31:2], 2'b00};
                    read_d       = (opcode == OP_LW);
                    write_d      = (opcode == OP_SW);
                    writedata_d  = rt_val;
                    byteenable_d = 4'b1111;
                end else begin
                    rf_we    = alu_we;
                    go_fetch = 1'b1;
                    fetch_pc = seq_pc;
                end
            end
            ST_MEM: begin
                // Loads take one extra cycle: readdata is valid the cycle after acceptance
                if (ld_wait_q) begin
                    ld_wait_d = 1'b0;
                    rf_we     = 1'b1;
                    rf_waddr  = rt;
                    rf_wdata  = readdata;
                    go_fetch  = 1'b1;
                end else if (waitrequest) begin
                    ld_wait_d = 1'b0;
                end else if (read_q) begin
                    read_d    = 1'b0;
                    ld_wait_d = 1'b1;
                end else begin
                    write_d  = 1'b0;
                    go_fetch = 1'b1;
                end
            end
            ST_HALT: begin
                active_d = 1'b0;
                read_d   = 1'b0;
                write_d  = 1'b0;
            end
            default: begin
                state_d  = ST_HALT;
                active_d = 1'b0;
                read_d   = 1'b0;
                write_d  = 1'b0;
            end
        endcase
        if (go_fetch) begin
            write_d      = 1'b0;
            address_d    = fetch_pc;
            byteenable_d = 4'b1111;
            if (fetch_pc == 32'd0) begin
                state_d  = ST_HALT;
                active_d = 1'b0;
                read_d   = 1'b0;
            end else begin
                state_d = ST_FETCH;
                read_d  = 1'b1;
            end
        end else begin
            fetch_pc = pc_q;
        end
    end

    // Control and bus-output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_VECTOR;
            instr_q      <= 32'd0;
            target_q     <= 32'd0;
            pending_q    <= 1'b0;
            ld_wait_q    <= 1'b0;
            active_q     <= 1'b1;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            address_q    <= RESET_VECTOR;
            writedata_q  <= 32'd0;
            byteenable_q <= 4'b0000;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            target_q     <= target_d;
            pending_q    <= pending_d;
            ld_wait_q    <= ld_wait_d;
            active_q     <= active_d;
            read_q       <= read_d;
            write_q      <= write_d;
            address_q    <= address_d;
            writedata_q  <= writedata_d;
            byteenable_q <= byteenable_d;
        end
    end

    assign active     = active_q;
    assign read       = read_q;
    assign write      = write_q;
    assign address    = address_q;
    assign writedata  = writedata_q;
    assign byteenable = byteenable_q;

endmodule

// File: tb/tb_mips_cpu_bus.sv
// Scoreboard bench for mips_cpu_bus: an instruction-level reference model
// predicts every bus transaction and the final $2; a bus monitor checks them.
module tb_mips_cpu_bus;

    localparam logic [31:0] RV = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        active, write, read, waitrequest = 1'b0;
    logic [31:0] register_v0, address, writedata, readdata = 32'd0;
    logic [3:0]  byteenable;

    always #5 clk = ~clk;

    mips_cpu_bus dut (
        .clk         (clk),
        .reset       (reset),
        .active      (active),
        .register_v0 (register_v0),
        .address     (address),
        .write       (write),
        .read        (read),
        .waitrequest (waitrequest),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .readdata    (readdata)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
    } txn_t;

    txn_t        exp_q[$];
    logic [31:0] mem     [bit [31:0]];
    logic [31:0] ref_mem [bit [31:0]];
    logic [31:0] prog[$];
    logic [31:0] ref_v0;
    int          vectors = 0;
    int          miscompares = 0;
    bit          stall_en = 1'b0;
    int          force_wr = 0;

    logic [5:0] rfns [14] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h21,
                              6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    logic [5:0] iops [7]  = '{6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'd0;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'd0;
    endfunction

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] s, input logic [4:0] t,
                                          input logic [4:0] d, input logic [4:0] sh);
        return {6'd0, s, t, d, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                                          input logic [15:0] imm);
        return {op, s, t, imm};
    endfunction

    task automatic push_exp(input logic [31:0] a, input logic w, input logic [31:0] d);
        txn_t t;
        t.addr = a;
        t.wr   = w;
        t.data = d;
        exp_q.push_back(t);
    endtask

    // Instruction-level reference: pc/npc pair gives the delay slot naturally
    task automatic run_ref();
        logic [31:0] r [32];
        logic [31:0] pc, npc, nxt, ins, a, b, res, ea, se, ze;
        logic [4:0]  wd;
        bit          we;
        for (int i = 0; i < 32; i++) r[i] = 32'd0;
        pc  = RV;
        npc = RV + 32'd4;
        for (int s = 0; s < 3000 && pc != 32'd0; s++) begin
            push_exp(pc, 1'b0, 32'd0);
            ins = ref_rd(pc);
            a   = r[ins[25:21]];
            b   = r[ins[20:16]];
            se  = {{16{ins[15]}}, ins[15:0]};
            ze  = {16'd0, ins[15:0]};
            nxt = npc + 32'd4;
            we  = 1'b0;
            wd  = ins[20:16];
            res = 32'd0;
            case (ins[31:26])
                6'h00: begin
                    wd = ins[15:11];
                    we = 1'b1;
                    case (ins[5:0])
                        6'h00: res = b << ins[10:6];
                        6'h02: res = b >> ins[10:6];
                        6'h03: res = $signed(b) >>> ins[10:6];
                        6'h04: res = b << a[4:0];
                        6'h06: res = b >> a[4:0];
                        6'h07: res = $signed(b) >>> a[4:0];
                        6'h08: begin we = 1'b0; nxt = a; end
                        6'h09: begin res = pc + 32'd8; nxt = a; end
                        6'h21: res = a + b;
                        6'h23: res = a - b;
                        6'h24: res = a & b;
                        6'h25: res = a | b;
                        6'h26: res = a ^ b;
                        6'h27: res = ~(a | b);
                        6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        6'h2B: res = (a < b) ? 32'd1 : 32'd0;
                        default: we = 1'b0;
                    endcase
                end
                6'h02: nxt = {npc[31:28], ins[25:0], 2'b00};
                6'h03: begin nxt = {npc[31:28], ins[25:0], 2'b00}; we = 1'b1; wd = 5'd31; res = pc + 32'd8; end
                6'h04: if (a == b) nxt = pc + 32'd4 + (se << 2);
                6'h05: if (a != b) nxt = pc + 32'd4 + (se << 2);
                6'h06: if ($signed(a) <= 32'sd0) nxt = pc + 32'd4 + (se << 2);
                6'h07: if ($signed(a) > 32'sd0) nxt = pc + 32'd4 + (se << 2);
                6'h09: begin we = 1'b1; res = a + se; end
                6'h0A: begin we = 1'b1; res = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0; end
                6'h0B: begin we = 1'b1; res = (a < se) ? 32'd1 : 32'd0; end
                6'h0C: begin we = 1'b1; res = a & ze; end
                6'h0D: begin we = 1'b1; res = a | ze; end
                6'h0E: begin we = 1'b1; res = a ^ ze; end
                6'h0F: begin we = 1'b1; res = {ins[15:0], 16'd0}; end
                6'h23: begin ea = a + se; push_exp(ea, 1'b0, 32'd0); res = ref_rd(ea); we = 1'b1; end
                6'h2B: begin ea = a + se; push_exp(ea, 1'b1, b); ref_mem[ea] = b; end
                default: we = 1'b0;
            endcase
            if (we && wd != 5'd0) r[wd] = res;
            pc  = npc;
            npc = nxt;
        end
        ref_v0 = r[2];
    endtask

    // Bus slave plus monitor: drives waitrequest/readdata, pops and compares accepted requests
    initial begin : monitor
        bit          pend, stalled, s_rd, s_wr;
        logic [31:0] pend_addr, s_addr, s_data;
        txn_t        t;
        pend    = 1'b0;
        stalled = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pend        = 1'b0;
                stalled     = 1'b0;
                waitrequest = 1'b0;
            end else begin
                readdata = pend ? rd_mem(pend_addr) : $urandom;
                pend     = 1'b0;
                if (read || write) check("rd_wr_exclusive", {31'd0, read & write}, 32'd0);
                if (stalled) begin
                    check("hold_address", address, s_addr);
                    check("hold_rd_wr", {30'd0, read, write}, {30'd0, s_rd, s_wr});
                    if (s_wr) check("hold_writedata", writedata, s_data);
                end
                if (read || write) begin
                    if (force_wr > 0) begin
                        waitrequest = 1'b1;
                        force_wr--;
                    end else if (stall_en) begin
                        waitrequest = ($urandom_range(0, 2) == 0);
                    end else begin
                        waitrequest = 1'b0;
                    end
                end else begin
                    waitrequest = $urandom_range(0, 1) != 0;
                end
                stalled = (read || write) && waitrequest;
                s_addr  = address;
                s_data  = writedata;
                s_rd    = read;
                s_wr    = write;
                if ((read || write) && !waitrequest) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_request: got addr %h write %0d expected none", address, write);
                    end else begin
                        t = exp_q.pop_front();
                        check("bus_address", address, t.addr);
                        check("bus_write", {31'd0, write}, {31'd0, t.wr});
                        check("bus_byteenable", {28'd0, byteenable}, 32'h0000_000F);
                        if (t.wr) check("bus_writedata", writedata, t.data);
                    end
                    if (write) mem[address] = writedata;
                    if (read) begin
                        pend      = 1'b1;
                        pend_addr = address;
                    end
                end
            end
        end
    end

    task automatic start_prog(input bit stall, input int forcew);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        exp_q.delete();
        stall_en = stall;
        force_wr = forcew;
        check("reset_active", {31'd0, active}, 32'd1);
        check("reset_rd_wr", {30'd0, read, write}, 32'd0);
        check("reset_byteenable", {28'd0, byteenable}, 32'd0);
        check("reset_v0", register_v0, 32'd0);
        mem.delete();
        ref_mem.delete();
        foreach (prog[i]) begin
            mem[RV + 32'(i) * 32'd4]     = prog[i];
            ref_mem[RV + 32'(i) * 32'd4] = prog[i];
        end
        run_ref();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic finish_prog(input string name, input bit plan, input logic [31:0] plan_v0);
        int c;
        c = 0;
        while (active && c < 4000) begin
            @(posedge clk);
            #1;
            c++;
        end
        check({name, "_halted"}, {31'd0, active}, 32'd0);
        check({name, "_v0"}, register_v0, ref_v0);
        if (plan) check({name, "_v0_plan"}, register_v0, plan_v0);
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check({name, "_idle_after_halt"}, {30'd0, read, write}, 32'd0);
    endtask

    task automatic prog_sll();
        prog.delete();
        prog.push_back(enc_i(6'h0F, 5'd0, 5'd3, 16'h0000));
        prog.push_back(enc_i(6'h0D, 5'd3, 5'd3, 16'h0003));
        prog.push_back(enc_r(6'h00, 5'd0, 5'd3, 5'd2, 5'd30));
        prog.push_back(enc_r(6'h08, 5'd0, 5'd0, 5'd0, 5'd0));
        prog.push_back(32'd0);
    endtask

    task automatic prog_ldst();
        prog.delete();
        prog.push_back(enc_i(6'h0F, 5'd0, 5'd3, 16'h1234));
        prog.push_back(enc_i(6'h0D, 5'd3, 5'd3, 16'h5678));
        prog.push_back(enc_i(6'h0F, 5'd0, 5'd4, 16'hBFC0));
        prog.push_back(enc_i(6'h2B, 5'd4, 5'd3, 16'h0100));
        prog.push_back(enc_i(6'h23, 5'd4, 5'd2, 16'h0100));
        prog.push_back(enc_r(6'h08, 5'd0, 5'd0, 5'd0, 5'd0));
        prog.push_back(32'd0);
    endtask

    task automatic gen_random();
        int          n, kind, k;
        bit          prev_br;
        logic [4:0]  s, t, d;
        n       = 24;
        prev_br = 1'b0;
        prog.delete();
        for (int r = 1; r < 8; r++) begin
            prog.push_back(enc_i(6'h0F, 5'd0, 5'(r), 16'($urandom)));
            prog.push_back(enc_i(6'h0D, 5'(r), 5'(r), 16'($urandom)));
        end
        for (int i = 0; i < n; i++) begin
            kind = $urandom_range(0, 9);
            s    = 5'($urandom_range(0, 7));
            t    = 5'($urandom_range(0, 7));
            d    = 5'($urandom_range(0, 7));
            if (kind == 8 && (prev_br || i > n - 2)) kind = 0;
            prev_br = (kind == 8);
            case (kind)
                0, 1, 2: prog.push_back(enc_r(rfns[$urandom_range(0, 13)], s, t, d, 5'($urandom_range(0, 31))));
                3, 4, 5: prog.push_back(enc_i(iops[$urandom_range(0, 6)], s, d, 16'($urandom)));
                6: prog.push_back(enc_i(6'h2B, 5'd0, t, 16'h0100 + 16'($urandom_range(0, 63)) * 16'd4));
                7: prog.push_back(enc_i(6'h23, 5'd0, d, 16'h0100 + 16'($urandom_range(0, 63)) * 16'd4));
                8: begin
                    k = $urandom_range(0, n - i - 1);
                    prog.push_back(enc_i(6'(4 + $urandom_range(0, 3)), s, t, 16'(k)));
                end
                default: prog.push_back({6'h3F, 26'($urandom)});
            endcase
        end
        for (int r = 1; r < 8; r++) prog.push_back(enc_i(6'h2B, 5'd0, 5'(r), 16'h0200 + 16'(r) * 16'd4));
        prog.push_back(enc_r(6'h08, 5'd0, 5'd0, 5'd0, 5'd0));
        prog.push_back(32'd0);
    endtask

    initial begin : stimulus
        prog_sll();
        start_prog(1'b0, 0);
        finish_prog("sll", 1'b1, 32'hC000_0000);

        prog_ldst();
        start_prog(1'b1, 0);
        finish_prog("ldst", 1'b1, 32'h1234_5678);

        prog.delete();
        prog.push_back(enc_r(6'h08, 5'd0, 5'd0, 5'd0, 5'd0));
        prog.push_back(enc_i(6'h09, 5'd0, 5'd2, 16'd5));
        start_prog(1'b0, 0);
        finish_prog("delay_slot", 1'b1, 32'd5);

        prog.delete();
        prog.push_back(enc_i(6'h09, 5'd0, 5'd2, 16'd7));
        prog.push_back(enc_i(6'h04, 5'd0, 5'd0, 16'd2));
        prog.push_back(enc_i(6'h09, 5'd2, 5'd2, 16'd1));
        prog.push_back(enc_i(6'h09, 5'd2, 5'd2, 16'd100));
        prog.push_back(enc_r(6'h08, 5'd0, 5'd0, 5'd0, 5'd0));
        prog.push_back(32'd0);
        start_prog(1'b1, 0);
        finish_prog("branch", 1'b1, 32'd8);

        prog_sll();
        start_prog(1'b0, 3);
        finish_prog("fetch_wait", 1'b1, 32'hC000_0000);

        prog.delete();
        prog.push_back({6'h03, 26'h3F0_0008});
        prog.push_back(32'd0);
        prog.push_back(enc_i(6'h09, 5'd2, 5'd2, 16'd3));
        prog.push_back(enc_r(6'h08, 5'd0, 5'd0, 5'd0, 5'd0));
        for (int i = 0; i < 4; i++) prog.push_back(32'd0);
        prog.push_back(enc_r(6'h08, 5'd31, 5'd0, 5'd0, 5'd0));
        prog.push_back(enc_i(6'h09, 5'd0, 5'd2, 16'h0010));
        start_prog(1'b1, 0);
        finish_prog("jal", 1'b1, 32'h0000_0013);

        // Abort a run part-way through; the following reset must leave no trace
        prog_sll();
        start_prog(1'b0, 0);
        repeat (14) @(posedge clk);
        prog_ldst();
        start_prog(1'b1, 0);
        finish_prog("ldst_after_abort", 1'b1, 32'h1234_5678);

        for (int p = 0; p < 8; p++) begin
            gen_random();
            start_prog(1'b1, 0);
            finish_prog("random", 1'b0, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
